// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encoding 2'd3 is unused; the FSM falls back to S_IDLE if it ever appears.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a controller (master) and the serial subtractor (slave).
// Handshake: start is taken on a rising edge only while ready=1, and x/y/bin are captured on that
// same edge. done is a one-cycle pulse that marks new d/bout. ready and done are never both high.
interface serial_sub_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, x, y, bin, input ready, done, d, bout);
  modport slave  (input start, x, y, bin, output ready, done, d, bout);
endinterface

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: a - b - c, producing the difference bit and the next borrow.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic bnext
);
  assign diff  = a ^ b ^ c;
  assign bnext = (~a & b) | (~a & c) | (b & c);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = x - y - bin, one bit per clock LSB first, through a single cell.
module serial_sub #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus,
  output logic [1:0]  dbg_state
);
  import serial_sub_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] x_r, y_r, work, work_next, d_r;
  logic             borrow, bout_r;
  logic             diff_w, bnext_w;
  logic             last_bit;

  assign idx      = cnt[IW-1:0];
  assign last_bit = (cnt == LAST);

  full_sub u_cell (
    .a    (x_r[idx]),
    .b    (y_r[idx]),
    .c    (borrow),
    .diff (diff_w),
    .bnext(bnext_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (last_bit)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Final word is assembled here so d can load the complete result on the last bit edge.
  always_comb begin
    work_next      = work;
    work_next[idx] = diff_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      borrow <= 1'b0;
      work   <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          x_r    <= bus.x;
          y_r    <= bus.y;
          borrow <= bus.bin;
          cnt    <= '0;
          work   <= '0;
        end
        S_RUN: begin
          work   <= work_next;
          borrow <= bnext_w;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            d_r    <= work_next;
            bout_r <= bnext_w;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.d     = d_r;
  assign bus.bout  = bout_r;
  assign dbg_state = state;

endmodule
